// File: rtl/aiso_reset_sync_pkg.sv
// rtl/aiso_reset_sync_pkg.sv - shared constants and legality check for the reset conditioner
//
// Purpose : single home for the release-chain depth default and its legal range,
//           so every instantiation site uses the same bounds.
// Ports   : none (package).

package aiso_reset_sync_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MAX_SYNC_STAGES     = 8;

    function automatic bit sync_stages_legal(input int stages);
        return (stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES);
    endfunction

endpackage : aiso_reset_sync_pkg

// File: rtl/aiso_reset_sync_if.sv
// rtl/aiso_reset_sync_if.sv - conditioned reset distribution interface
//
// Purpose : carries the conditioned, clock-aligned reset from the conditioner
//           to the logic it resets.
// Signals : aiso_reset - conditioned reset, active-high.
// Modports: master - the conditioner (drives aiso_reset)
//           slave  - reset consumers (read aiso_reset)

interface aiso_reset_sync_if;

    logic aiso_reset;

    modport master (output aiso_reset);
    modport slave  (input  aiso_reset);

endinterface : aiso_reset_sync_if

// File: rtl/aiso_reset_sync.sv
// rtl/aiso_reset_sync.sv - reset conditioner: 1-edge assertion, SYNC_STAGES-edge release
//
// Purpose : turns the raw reset request into the design-wide registered reset.
//           Assertion is taken on the first edge that samples reset high; release
//           happens only after reset has been sampled low on SYNC_STAGES
//           consecutive edges.
// Params  : SYNC_STAGES   - release chain depth, legal 2..8 (release latency)
//           INIT_ASSERTED - power-up value of every chain flop
// Ports   : clk   - system clock, rising edge active
//           reset - raw reset request, synchronous, active-high
//           aiso  - interface master; aiso.aiso_reset is the conditioned reset,
//                   driven straight from the last chain flop

module aiso_reset_sync
    import aiso_reset_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter bit INIT_ASSERTED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    aiso_reset_sync_if.master  aiso
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
        $error("aiso_reset_sync: SYNC_STAGES=%0d outside legal range %0d..%0d",
               SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
    end

    // Each stage is a separate flop; a 1 means "reset active". The first stage
    // shifts in 0 while reset is low, so the last stage only clears once that
    // 0 has walked the full chain. Any high sample refills every stage at once,
    // which restarts the release count without ever dropping the output.
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_stage
        logic q = INIT_ASSERTED;
        logic d_in;

        if (i == 0) begin : g_head
            assign d_in = 1'b0;
        end else begin : g_body
            assign d_in = g_stage[i-1].q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                q <= 1'b1;
            end else begin
                q <= d_in;
            end
        end
    end

    assign aiso.aiso_reset = g_stage[SYNC_STAGES-1].q;

endmodule : aiso_reset_sync

// File: tb/tb_aiso_reset_sync.sv
// tb/tb_aiso_reset_sync.sv - directed checks of the reset conditioner across depths and init values

module tb_aiso_reset_sync;

    localparam int N_DUT = 6;

    // 0: S=2 init1 (main), 1: S=4, 2: S=8, 3: S=2 init1 power-up, 4: S=2 init0 power-up, 5: S=3
    function automatic int stages_of(input int i);
        case (i)
            1:       return 4;
            2:       return 8;
            5:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit init_of(input int i);
        return (i == 4) ? 1'b0 : 1'b1;
    endfunction

    logic             clk = 1'b0;
    logic [N_DUT-1:0] rst_v = '0;
    wire  [N_DUT-1:0] out_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        aiso_reset_sync_if u_if ();

        aiso_reset_sync #(
            .SYNC_STAGES   (stages_of(g)),
            .INIT_ASSERTED (init_of(g))
        ) u_dut (
            .clk   (clk),
            .reset (rst_v[g]),
            .aiso  (u_if.master)
        );

        assign out_v[g] = u_if.aiso_reset;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst;
        logic exp;
    } vec_t;

    // Drain, assert for 3 edges, release; release must take exactly n edges.
    task automatic release_run(input int idx, input int n);
        rst_v[idx] = 1'b0;
        repeat (n + 1) @(posedge clk);
        #1 check($sformatf("drained_s%0d", n), out_v[idx], 1'b0);
        @(negedge clk) rst_v[idx] = 1'b1;
        @(posedge clk);
        #1 check($sformatf("assert_lat_s%0d", n), out_v[idx], 1'b1);
        repeat (2) @(posedge clk);
        #1 check($sformatf("assert_hold_s%0d", n), out_v[idx], 1'b1);
        @(negedge clk) rst_v[idx] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1 check($sformatf("release_s%0d_edge%0d", n, k), out_v[idx], (k < n));
        end
    endtask

    initial begin
        vec_t vecs[12];

        // Power-up and scenario 1 share an absolute timeline.
        rst_v[0] = 1'b1;
        #1;
        check("pwr_init1_t0", out_v[3], 1'b1);
        check("pwr_init0_t0", out_v[4], 1'b0);
        #5; // t=6, after edge 1
        check("pwr_init1_edge1", out_v[3], 1'b1);
        check("pwr_init0_edge1", out_v[4], 1'b0);
        check("s1_asserted_t6", out_v[0], 1'b1);
        #4 rst_v[0] = 1'b0; // t=10
        #6; // t=16, after edge 2
        check("pwr_init1_edge2", out_v[3], 1'b0);
        check("pwr_init0_edge2", out_v[4], 1'b0);
        #10; // t=26
        check("s1_released_t26", out_v[0], 1'b0);
        #4 rst_v[0] = 1'b1; // t=30
        #0 check("s1_no_comb_path_t30", out_v[0], 1'b0);
        #1 check("s1_mid_cycle_t31", out_v[0], 1'b0);
        #9 check("s1_one_edge_t40", out_v[0], 1'b1);

        // Table on the S=2 instance, starting from a full chain.
        vecs[0]  = '{1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk) rst_v[0] = vecs[i].rst;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), out_v[0], vecs[i].exp);
        end

        // Scenario 2 and the depth sweep.
        release_run(0, 2);
        release_run(1, 4);
        release_run(2, 8);

        // Scenario 3: re-assertion mid-release on S=3.
        rst_v[5] = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("s3_drained", out_v[5], 1'b0);
        @(negedge clk) rst_v[5] = 1'b1;
        @(posedge clk);
        #1 check("s3_assert", out_v[5], 1'b1);
        @(negedge clk) rst_v[5] = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1 check($sformatf("s3_drain_edge%0d", k), out_v[5], 1'b1);
        end
        @(negedge clk) rst_v[5] = 1'b1;
        @(posedge clk);
        #1 check("s3_reassert", out_v[5], 1'b1);
        @(negedge clk) rst_v[5] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("s3_final_edge%0d", k), out_v[5], (k < 3));
        end

        // Scenario 4: 3 ns pulse strictly between edges on the idle S=2 instance.
        @(posedge clk);
        #2 rst_v[0] = 1'b1;
        #3 rst_v[0] = 1'b0;
        check("s4_during_pulse", out_v[0], 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1 check($sformatf("s4_edge%0d", k), out_v[0], 1'b0);
        end

        // Steady state: reset held high keeps output high.
        @(negedge clk) rst_v[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 check($sformatf("held_high_edge%0d", k), out_v[1], 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_aiso_reset_sync
